vga_timing_scan: RTL and testbench

Parametrised VGA raster generator; successor to the fixed 640x480 VGA block. Produces HSYNC/VSYNC/DE from configurable porch/sync/active timing, issues a read-ahead `ReadMem` strobe to the line/frame buffer, and drives RGB from either buffer data or a built-in test-pattern engine. Adds active-pixel coordinates, a frame-start pulse and a sticky data-underflow flag. Sits between the frame-buffer read port and the board VGA pins.

---
 rtl/vga_timing_scan_if.sv | 12 +
 rtl/vga_timing_scan.sv | 151 +++++++++++++++
 tb/tb_vga_timing_scan.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_scan_if.sv
// Frame-buffer read port: the raster generator (master) strobes ReadMem and
// the line/frame buffer (slave) answers with ROWdata/DataValid.
interface vga_timing_scan_if #(
    parameter int CW = 4
);
    logic            ReadMem;
    logic [3*CW-1:0] ROWdata;
    logic            DataValid;

    modport master (output ReadMem, input ROWdata, input DataValid);
    modport slave  (input ReadMem, output ROWdata, output DataValid);
endinterface

// File: rtl/vga_timing_scan.sv
// Parametrised VGA raster generator: sync/DE timing, read-ahead buffer strobe,
// buffer pass-through or built-in test patterns, coordinates and underflow flag.
module vga_timing_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 4,
    parameter int PREFETCH = 2,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              SyncVsync,
    input  logic [1:0]        Mode,
    vga_timing_scan_if.master fb,
    output logic [CW-1:0]     RED,
    output logic [CW-1:0]     GRN,
    output logic [CW-1:0]     BLU,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              DE,
    output logic [XW-1:0]     PixX,
    output logic [YW-1:0]     PixY,
    output logic              FrameStart,
    output logic              Underflow
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    logic [HW-1:0]   hcnt_reg;
    logic [VW-1:0]   vcnt_reg;
    logic            hsync_reg, vsync_reg, de_reg, read_reg, fs_reg, uf_reg;
    logic [XW-1:0]   pix_x_reg;
    logic [YW-1:0]   pix_y_reg;
    logic [1:0]      mode_reg;
    logic [3*CW-1:0] pat_reg;

    int              hx, vy, px_now, py_now;
    logic            h_sync_now, v_sync_now, v_act_now, h_pre_now, de_now, origin_now;
    logic [7:0]      bar_ge;
    logic [2:0]      bar_now;
    logic            border_now;
    logic [3*CW-1:0] pat_now;
    logic [3*CW-1:0] rgb;

    // Decode of the current counter position; everything registered below lags it by one cycle.
    always_comb begin
        hx         = int'(hcnt_reg);
        vy         = int'(vcnt_reg);
        px_now     = hx - H_START;
        py_now     = vy - V_START;
        h_sync_now = hx < H_SYNC;
        v_sync_now = vy < V_SYNC;
        v_act_now  = (vy >= V_START) && (vy < V_START + V_ACTIVE);
        de_now     = v_act_now && (hx >= H_START) && (hx < H_START + H_ACTIVE);
        h_pre_now  = (hx + PREFETCH >= H_START) && (hx + PREFETCH < H_START + H_ACTIVE);
        origin_now = (hcnt_reg == '0) && (vcnt_reg == '0);
        border_now = (px_now == 0) || (px_now == H_ACTIVE - 1) ||
                     (py_now == 0) || (py_now == V_ACTIVE - 1);
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bar
            assign bar_ge[gi] = (px_now >= gi * BAR_W);
        end
    endgenerate

    // Bar index is the highest threshold reached, so the last bar absorbs any remainder.
    always_comb begin
        bar_now = '0;
        for (int i = 0; i < 8; i++) begin
            if (bar_ge[i]) bar_now = 3'(i);
        end
        pat_now = '0;
        case (mode_reg)
            2'd1:    pat_now = {3*CW{1'b1}};
            2'd2:    pat_now = {{CW{~bar_now[0]}}, {CW{~bar_now[2]}}, {CW{~bar_now[1]}}};
            2'd3:    pat_now = border_now ? {3*CW{1'b1}} : {{CW{1'b1}}, {2*CW{1'b0}}};
            default: pat_now = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
            hsync_reg <= ~HS_POL;
            vsync_reg <= ~VS_POL;
            de_reg    <= 1'b0;
            read_reg  <= 1'b0;
            pix_x_reg <= '0;
            pix_y_reg <= '0;
            fs_reg    <= 1'b0;
            uf_reg    <= 1'b0;
            mode_reg  <= 2'd0;
            pat_reg   <= '0;
        end else begin
            if (SyncVsync) begin
                hcnt_reg <= '0;
                vcnt_reg <= '0;
            end else if (hcnt_reg == HW'(H_TOTAL - 1)) begin
                hcnt_reg <= '0;
                vcnt_reg <= (vcnt_reg == VW'(V_TOTAL - 1)) ? '0 : vcnt_reg + VW'(1);
            end else begin
                hcnt_reg <= hcnt_reg + HW'(1);
            end
            hsync_reg <= h_sync_now ? HS_POL : ~HS_POL;
            vsync_reg <= v_sync_now ? VS_POL : ~VS_POL;
            de_reg    <= de_now;
            read_reg  <= v_act_now && h_pre_now;
            pix_x_reg <= de_now ? XW'(px_now) : '0;
            pix_y_reg <= de_now ? YW'(py_now) : '0;
            fs_reg    <= origin_now;
            pat_reg   <= de_now ? pat_now : '0;
            if (origin_now) mode_reg <= Mode;
            if (mode_reg == 2'd0 && de_reg && !fb.DataValid) uf_reg <= 1'b1;
            else if (origin_now)                              uf_reg <= 1'b0;
        end
    end

    // Pass-through colour is combinational so buffer latency equals the ReadMem lead.
    always_comb begin
        rgb = pat_reg;
        if (mode_reg == 2'd0) rgb = de_reg ? fb.ROWdata : '0;
    end

    assign RED        = rgb[CW-1:0];
    assign GRN        = rgb[2*CW-1:CW];
    assign BLU        = rgb[3*CW-1:2*CW];
    assign HSYNC      = hsync_reg;
    assign VSYNC      = vsync_reg;
    assign DE         = de_reg;
    assign PixX       = pix_x_reg;
    assign PixY       = pix_y_reg;
    assign FrameStart = fs_reg;
    assign Underflow  = uf_reg;
    assign fb.ReadMem = read_reg;
endmodule

// File: tb/tb_vga_timing_scan.sv
// Bench for vga_timing_scan on a 15x7 raster: linear-time reference model
// checked every cycle, plus literal counts and pixel colours.
module tb_vga_timing_scan;
    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam bit HS_POL = 1'b1, VS_POL = 1'b1;
    localparam int CW = 4, PREFETCH = 2, RW = 3 * CW;
    localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FRAME = HT * VT;
    localparam int HS0 = H_SYNC + H_BP, VS0 = V_SYNC + V_BP;
    localparam int XW = $clog2(H_ACTIVE), YW = $clog2(V_ACTIVE);
    // {R,G,B} on/off per bar
    localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    logic          clk = 1'b0, rstn = 1'b0, sync_vsync = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [CW-1:0] RED, GRN, BLU;
    logic          HSYNC, VSYNC, DE, FrameStart, Underflow;
    logic [XW-1:0] PixX;
    logic [YW-1:0] PixY;

    vga_timing_scan_if #(.CW(CW)) fb();

    vga_timing_scan #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .PREFETCH(PREFETCH)
    ) dut (
        .clk(clk), .rstn(rstn), .SyncVsync(sync_vsync), .Mode(mode), .fb(fb),
        .RED(RED), .GRN(GRN), .BLU(BLU), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
        .PixX(PixX), .PixY(PixY), .FrameStart(FrameStart), .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_de, n_rd, n_hs, n_vs;
    logic [RW-1:0] rgb_at [V_ACTIVE][H_ACTIVE];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input int v, input int lo, input int n);
        return (v >= lo) && (v < lo + n);
    endfunction

    function automatic bit vis(input int p);
        return in_win(p % HT, HS0, H_ACTIVE) && in_win(p / HT, VS0, V_ACTIVE);
    endfunction

    function automatic logic [RW-1:0] exp_rgb(input logic de, input logic [1:0] m,
                                              input int x, input int y, input logic [RW-1:0] row);
        logic [2:0]    c;
        int            bar;
        logic [CW-1:0] r, g, b;
        if (!de) return '0;
        if (m == 2'd0) return row;
        if (m == 2'd1) c = 3'b111;
        else if (m == 2'd2) begin
            bar = x / (H_ACTIVE / 8);
            if (bar > 7) bar = 7;
            c = BAR_RGB[bar];
        end else begin
            c = (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) ? 3'b111 : 3'b001;
        end
        r = c[2] ? '1 : '0;
        g = c[1] ? '1 : '0;
        b = c[0] ? '1 : '0;
        return {b, g, r};
    endfunction

    // Reference model: m_pos is the raster position as a linear time index within the frame.
    int         m_pos = 0, e_x = 0, e_y = 0;
    bit         model_valid = 1'b0;
    logic       e_hs, e_vs, e_de, e_rd, e_fs, e_uf;
    logic [1:0] e_mode;

    always @(posedge clk) begin
        if (!rstn) begin
            m_pos <= 0;
            e_hs <= ~HS_POL; e_vs <= ~VS_POL; e_de <= 1'b0; e_rd <= 1'b0;
            e_fs <= 1'b0; e_uf <= 1'b0; e_mode <= 2'd0; e_x <= 0; e_y <= 0;
        end else begin
            e_hs <= (m_pos % HT < H_SYNC) ? HS_POL : ~HS_POL;
            e_vs <= (m_pos / HT < V_SYNC) ? VS_POL : ~VS_POL;
            e_de <= vis(m_pos);
            e_rd <= in_win(m_pos % HT + PREFETCH, HS0, H_ACTIVE) && in_win(m_pos / HT, VS0, V_ACTIVE);
            e_x  <= vis(m_pos) ? (m_pos % HT - HS0) : 0;
            e_y  <= vis(m_pos) ? (m_pos / HT - VS0) : 0;
            e_fs <= (m_pos == 0);
            if (m_pos == 0) e_mode <= mode;
            if (e_mode == 2'd0 && e_de && !fb.DataValid) e_uf <= 1'b1;
            else if (m_pos == 0)                          e_uf <= 1'b0;
            m_pos <= sync_vsync ? 0 : (m_pos + 1) % FRAME;
        end
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("HSYNC", 32'(HSYNC), 32'(e_hs));
            chk("VSYNC", 32'(VSYNC), 32'(e_vs));
            chk("DE", 32'(DE), 32'(e_de));
            chk("ReadMem", 32'(fb.ReadMem), 32'(e_rd));
            chk("PixX", 32'(PixX), e_x);
            chk("PixY", 32'(PixY), e_y);
            chk("FrameStart", 32'(FrameStart), 32'(e_fs));
            chk("Underflow", 32'(Underflow), 32'(e_uf));
            chk("RGB", 32'({BLU, GRN, RED}), 32'(exp_rgb(e_de, e_mode, e_x, e_y, fb.ROWdata)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call on a FrameStart output cycle; returns at the next one (or after a bounded timeout).
    task automatic measure_frame(input int chg_at, input logic [1:0] chg_mode,
                                 input bit rand_row, output int len);
        int last_rd_rise;
        bit prev_rd, prev_de;
        n_de = 0; n_rd = 0; n_hs = 0; n_vs = 0;
        len = 0; prev_rd = 1'b0; prev_de = 1'b0; last_rd_rise = -100;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c > 0 && FrameStart) break;
            len++;
            if (DE) begin
                n_de++;
                rgb_at[PixY][PixX] = {BLU, GRN, RED};
            end
            if (fb.ReadMem) n_rd++;
            if (HSYNC == HS_POL) n_hs++;
            if (VSYNC == VS_POL) n_vs++;
            if (fb.ReadMem && !prev_rd) last_rd_rise = c;
            if (DE && !prev_de) chk("rd_lead", c - last_rd_rise, PREFETCH);
            prev_rd = fb.ReadMem;
            prev_de = DE;
            if (c == chg_at) mode = chg_mode;
            if (rand_row) fb.ROWdata = RW'($urandom);
            tick();
        end
    endtask

    task automatic wait_de();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (DE) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("de_wait", 32'(ok), 1);
    endtask

    initial begin
        int   len;
        bit   ok;
        logic last_uf;
        fb.ROWdata = '0;
        fb.DataValid = 1'b1;
        repeat (3) tick();
        chk("rst_HSYNC", 32'(HSYNC), 0);
        chk("rst_VSYNC", 32'(VSYNC), 0);
        chk("rst_DE", 32'(DE), 0);
        chk("rst_FrameStart", 32'(FrameStart), 0);
        rstn = 1'b1;
        tick();
        chk("first_FrameStart", 32'(FrameStart), 1);
        chk("first_HSYNC", 32'(HSYNC), 1);
        chk("first_VSYNC", 32'(VSYNC), 1);

        // Frame 1: pass-through with random data; bars requested mid-frame
        measure_frame(40, 2'd2, 1'b1, len);
        chk("f1_len", len, 105);
        chk("f1_de_count", n_de, 32);
        chk("f1_rd_count", n_rd, 32);
        chk("f1_hsync_cycles", n_hs, 21);
        chk("f1_vsync_cycles", n_vs, 15);
        fb.ROWdata = '0;

        // Frame 2: colour bars, one pixel per bar
        measure_frame(40, 2'd3, 1'b0, len);
        chk("f2_len", len, 105);
        chk("f2_de_count", n_de, 32);
        chk("bar_white", 32'(rgb_at[0][0]), 32'h0FFF);
        chk("bar_yellow", 32'(rgb_at[0][1]), 32'h00FF);
        chk("bar_cyan", 32'(rgb_at[2][2]), 32'h0FF0);
        chk("bar_green", 32'(rgb_at[1][3]), 32'h00F0);
        chk("bar_magenta", 32'(rgb_at[3][4]), 32'h0F0F);
        chk("bar_red", 32'(rgb_at[0][5]), 32'h000F);
        chk("bar_blue", 32'(rgb_at[1][6]), 32'h0F00);
        chk("bar_black", 32'(rgb_at[3][7]), 32'h0000);

        // Frame 3: border
        measure_frame(40, 2'd0, 1'b0, len);
        chk("brd_top", 32'(rgb_at[0][3]), 32'h0FFF);
        chk("brd_left", 32'(rgb_at[1][0]), 32'h0FFF);
        chk("brd_right", 32'(rgb_at[2][7]), 32'h0FFF);
        chk("brd_bottom", 32'(rgb_at[3][5]), 32'h0FFF);
        chk("brd_inner_a", 32'(rgb_at[1][3]), 32'h0F00);
        chk("brd_inner_b", 32'(rgb_at[2][6]), 32'h0F00);

        // Frame 4: one missing word during DE, sticky until the next frame
        wait_de();
        fb.DataValid = 1'b0;
        tick();
        fb.DataValid = 1'b1;
        chk("uf_set", 32'(Underflow), 1);
        last_uf = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (FrameStart) begin
                ok = 1'b1;
                break;
            end
            last_uf = Underflow;
            tick();
        end
        chk("uf_fs_seen", 32'(ok), 1);
        chk("uf_hold", 32'(last_uf), 1);
        chk("uf_clear", 32'(Underflow), 0);

        // Underflow again, then a mid-frame restart
        wait_de();
        fb.DataValid = 1'b0;
        tick();
        fb.DataValid = 1'b1;
        repeat (20) tick();
        chk("uf_pre_sync", 32'(Underflow), 1);
        sync_vsync = 1'b1;
        tick();
        sync_vsync = 1'b0;
        chk("sync_fs_early", 32'(FrameStart), 0);
        tick();
        chk("sync_fs", 32'(FrameStart), 1);
        chk("sync_uf_clear", 32'(Underflow), 0);
        measure_frame(-1, 2'd0, 1'b0, len);
        chk("post_sync_len", len, 105);
        chk("post_sync_de", n_de, 32);

        // Held restart keeps the raster parked at the origin
        sync_vsync = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sync_hold_fs", 32'(FrameStart), 1);
            tick();
        end
        sync_vsync = 1'b0;

        // Mid-line reset
        wait_de();
        rstn = 1'b0;
        tick();
        chk("midrst_DE", 32'(DE), 0);
        chk("midrst_ReadMem", 32'(fb.ReadMem), 0);
        chk("midrst_HSYNC", 32'(HSYNC), 0);
        chk("midrst_PixX", 32'(PixX), 0);
        rstn = 1'b1;
        tick();
        chk("rerelease_fs", 32'(FrameStart), 1);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
